cal_eep_spi_resp: RTL and testbench

SPI responder that models the 64 x 8 calibration EEPROM at the far end of the command processor's SPI link, selected by slave select 3'b100. It decodes 16-bit write and read frames, holds the gain/offset calibration bytes, and returns read data in the following frame. It sits on the system clock, oversamples the SPI pins, and is the synthesizable stand-in used in the full-chip bench and on the FPGA build.

---
 rtl/cal_eep_pkg.sv | 24 ++
 rtl/spi_pin_sync.sv | 32 +++
 rtl/cal_eep_spi_resp.sv | 121 ++++++++++++
 tb/tb_cal_eep_spi_resp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cal_eep_pkg.sv
// Opcodes, frame layout and FSM states for the calibration EEPROM SPI link.
// The command processor imports the same opcodes.
package cal_eep_pkg;

  localparam logic [1:0] EEP_OP_RD   = 2'b00;
  localparam logic [1:0] EEP_OP_WR   = 2'b01;
  localparam int         EEP_FRAME_W = 16;
  localparam int         EEP_ADDR_W  = 6;
  localparam int         EEP_DATA_W  = 8;
  localparam int         EEP_DEPTH   = 1 << EEP_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } eep_state_e;

  typedef struct packed {
    logic [1:0]            op;
    logic [EEP_ADDR_W-1:0] addr;
    logic [EEP_DATA_W-1:0] data;
  } eep_frame_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer plus edge detect for one oversampled SPI pin.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset loads the live pin value so a pin already low (SS_n mid-frame)
  // does not show up as a fresh edge once reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{pin}};
      prev_q <= pin;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/cal_eep_spi_resp.sv
// SPI responder modelling the 64x8 calibration EEPROM: 16-bit write/read
// frames, read data returned in the following frame, backdoor preload port.
module cal_eep_spi_resp
  import cal_eep_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       bd_we,
  input  logic [5:0] bd_addr,
  input  logic [7:0] bd_wdata,
  output logic       frame_err,
  output logic       wr_done
);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_lvls;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .rst(rst), .pin(SS_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .pin(SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .rst(rst), .pin(MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_lvls = ss_lvl ^ sclk_lvl ^ mosi_rise ^ mosi_fall;

  eep_state_e              state_q, state_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [EEP_FRAME_W-1:0]  rx_q, rx_d;
  logic [EEP_FRAME_W-1:0]  tx_q, tx_d;
  logic [EEP_DATA_W-1:0]   rd_hold;
  logic [EEP_DATA_W-1:0]   mem [EEP_DEPTH];
  eep_frame_t              frame;
  logic                    commit_wr, commit_rd, commit_err;

  assign frame = rx_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    commit_wr  = 1'b0;
    commit_rd  = 1'b0;
    commit_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = SHIFT;
          tx_d      = {8'h00, rd_hold};
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_d = {rx_q[EEP_FRAME_W-2:0], mosi_lvl};
          if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (sclk_fall) tx_d = {tx_q[EEP_FRAME_W-2:0], 1'b0};
        if (ss_rise)   state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (bit_cnt_q == 5'(EEP_FRAME_W)) begin
          commit_wr = (frame.op == EEP_OP_WR);
          commit_rd = (frame.op == EEP_OP_RD);
        end else begin
          commit_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      rd_hold   <= '0;
      MISO      <= 1'b0;
      wr_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      MISO      <= tx_q[EEP_FRAME_W-1];
      wr_done   <= commit_wr;
      frame_err <= commit_err;
      if (commit_rd) rd_hold <= mem[frame.addr];
    end
  end

  // Array survives reset. The SPI write is issued last so it wins a
  // same-cycle, same-address collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (commit_wr && !rst) mem[frame.addr] <= frame.data;
  end

endmodule

// File: tb/tb_cal_eep_spi_resp.sv
// Scoreboard bench for cal_eep_spi_resp: directed plan plus random frames.
module tb_cal_eep_spi_resp;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SS_n = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       bd_we = 1'b0;
  logic [5:0] bd_addr = '0;
  logic [7:0] bd_wdata = '0;
  logic       MISO, frame_err, wr_done;

  always #5 clk = ~clk;

  cal_eep_spi_resp #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .frame_err(frame_err), .wr_done(wr_done)
  );

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          wr;
    int          err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_mem [64];
  logic [7:0] m_rd = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master-side observation: MISO sampled on every SCLK rise, pulses counted.
  logic [31:0] cap_sh = '0;
  int          cap_n = 0;
  int          wr_tot = 0;
  int          err_tot = 0;

  always @(posedge SCLK) begin
    cap_sh <= {cap_sh[30:0], MISO};
    cap_n  <= cap_n + 1;
  end

  always @(negedge clk) begin
    if (wr_done === 1'b1)   wr_tot  <= wr_tot + 1;
    if (frame_err === 1'b1) err_tot <= err_tot + 1;
  end

  initial begin
    int n0, w0, e0, nb;
    logic [31:0] msk;
    exp_t e;
    forever begin
      @(negedge SS_n);
      n0 = cap_n; w0 = wr_tot; e0 = err_tot;
      @(posedge SS_n);
      repeat (SYNC + 4) @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard: frame seen with no expectation queued");
      end else begin
        e   = q.pop_front();
        nb  = cap_n - n0;
        msk = (nb >= 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
        check("miso_word", cap_sh & msk, e.bits);
        check("wr_done_count", 32'(wr_tot - w0), 32'(e.wr));
        check("frame_err_count", 32'(err_tot - e0), 32'(e.err));
      end
    end
  end

  task automatic bd_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_rd = 8'h00;
  endtask

  // Issue one frame; rst_at >= 0 pulses reset after that many bits.
  task automatic spi_frame(input logic [15:0] f, input int nbits, input int rst_at,
                           input bit collide, input logic [7:0] cdata);
    logic [31:0] eb;
    logic [15:0] w;
    exp_t        e;
    eb = '0;
    w  = {8'h00, m_rd};
    if (rst_at >= 0) w = w & ~(16'hFFFF >> rst_at);
    for (int i = 0; i < nbits; i++) eb = {eb[30:0], (i < 16) ? w[15-i] : 1'b0};
    e.bits  = eb;
    e.nbits = nbits;
    e.wr    = (rst_at < 0 && nbits == 16 && f[15:14] == 2'b01) ? 1 : 0;
    e.err   = (rst_at < 0 && nbits != 16) ? 1 : 0;
    q.push_back(e);
    if (rst_at >= 0) m_rd = 8'h00;
    else if (nbits == 16) begin
      if (collide) m_mem[f[13:8]] = cdata;
      if (f[15:14] == 2'b01)      m_mem[f[13:8]] = f[7:0];
      else if (f[15:14] == 2'b00) m_rd = m_mem[f[13:8]];
    end
    @(negedge clk); SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? f[15-i] : 1'($urandom);
      repeat (HALF) @(negedge clk); SCLK = 1'b1;
      repeat (HALF) @(negedge clk); SCLK = 1'b0;
      if (i + 1 == rst_at) begin
        repeat (4) @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk); SS_n = 1'b1;
    if (collide) begin
      repeat (SYNC + 1) @(negedge clk);
      bd_we = 1'b1; bd_addr = f[13:8]; bd_wdata = cdata;
      @(negedge clk); bd_we = 1'b0;
      repeat (HALF) @(negedge clk);
    end else begin
      repeat (HALF + 2) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_miso", 32'(MISO), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_wr_done", 32'(wr_done), 32'h0);
    for (int a = 0; a < 64; a++) bd_write(6'(a), 8'($urandom));

    spi_frame(16'h4A5C, 16, -1, 0, 8'h00);
    spi_frame(16'h0A00, 16, -1, 0, 8'h00);
    spi_frame(16'h0000, 16, -1, 0, 8'h00);

    bd_write(6'h3F, 8'hDD);
    spi_frame(16'h3F00, 16, -1, 0, 8'h00);
    spi_frame(16'h0000, 16, -1, 0, 8'h00);
    spi_frame(16'h3F00, 16, -1, 0, 8'h00);
    do_reset();
    spi_frame(16'h3F00, 16, -1, 0, 8'h00);
    spi_frame(16'h0000, 16, -1, 0, 8'h00);

    spi_frame(16'h4A77, 15, -1, 0, 8'h00);
    spi_frame(16'h4A77, 17, -1, 0, 8'h00);
    spi_frame(16'h0A00, 16, -1, 0, 8'h00);
    spi_frame(16'hC512, 16, -1, 0, 8'h00);
    spi_frame(16'h0000, 16, -1, 0, 8'h00);

    spi_frame(16'h4B99, 16, 8, 0, 8'h00);
    spi_frame(16'h0B00, 16, -1, 0, 8'h00);
    spi_frame(16'h0000, 16, -1, 0, 8'h00);

    spi_frame(16'h4522, 16, -1, 1, 8'h11);
    spi_frame(16'h0500, 16, -1, 0, 8'h00);
    spi_frame(16'h0000, 16, -1, 0, 8'h00);

    for (int k = 0; k < 40; k++) begin
      int          r, nb;
      logic [1:0]  op;
      logic [15:0] f;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b01 : (r < 8) ? 2'b00 : {1'b1, 1'($urandom)};
      f  = {op, 6'($urandom), 8'($urandom)};
      nb = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
      if ($urandom_range(0, 5) == 0) bd_write(6'($urandom), 8'($urandom));
      if ($urandom_range(0, 15) == 0) do_reset();
      spi_frame(f, nb, -1, 0, 8'h00);
    end

    repeat (30) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
